// File: rtl/fetch_stage_if.sv
// Instruction-bus handshake between the fetch stage (master) and instruction memory (slave).
// ireq_valid/ireq_addr are held until iresp_data_ok; iresp_data is valid only with iresp_data_ok.
interface fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok;
    logic [31:0]     iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction bus and registers one fetch slot for decode.
// data_ok to slot in one cycle; stall freezes the slot and parks an early response in a one-entry buffer.
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   ibus,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dataF_en,
    output logic [XLEN-1:0] dataF_pc,
    output logic [31:0]     dataF_raw_instr,
    output logic            dataF_is_exception,
    output logic [3:0]      dataF_exception
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_EXC
    } state_t;

    typedef struct packed {
        logic            en;
        logic [XLEN-1:0] pc;
        logic [31:0]     raw_instr;
        logic            is_exception;
        logic [3:0]      exception;
    } fetch_data_t;

    localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] drain_addr_nxt;
    logic [31:0]     hold_instr;
    logic [31:0]     hold_instr_nxt;
    fetch_data_t     data_q;
    fetch_data_t     data_nxt;
    logic            req_vld;
    logic [XLEN-1:0] req_addr;
    logic            pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);
    assign pc_plus4   = pc + XLEN'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= PC_RESET;
            drain_addr <= '0;
            hold_instr <= '0;
            data_q     <= '0;
        end else begin
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            hold_instr <= hold_instr_nxt;
            data_q     <= data_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        hold_instr_nxt = hold_instr;
        data_nxt       = data_q;
        req_vld        = 1'b0;
        req_addr       = pc;

        case (state)
            S_REQ: begin
                if (pc_aligned) begin
                    req_vld = 1'b1;
                    if (redirect_valid) begin
                        pc_nxt = redirect_pc;
                        // An unanswered request stays on the bus; its response must be swallowed.
                        if (!ibus.iresp_data_ok) begin
                            drain_addr_nxt = pc;
                            state_nxt      = S_DRAIN;
                        end
                    end else if (ibus.iresp_data_ok) begin
                        if (!stall) begin
                            data_nxt.en           = 1'b1;
                            data_nxt.pc           = pc;
                            data_nxt.raw_instr    = ibus.iresp_data;
                            data_nxt.is_exception = 1'b0;
                            data_nxt.exception    = '0;
                            pc_nxt                = pc_plus4;
                        end else begin
                            hold_instr_nxt = ibus.iresp_data;
                            state_nxt      = S_HOLD;
                        end
                    end else if (!stall) begin
                        data_nxt.en = 1'b0;
                    end
                end else begin
                    if (redirect_valid) begin
                        pc_nxt = redirect_pc;
                    end else if (!stall) begin
                        data_nxt.en           = 1'b1;
                        data_nxt.pc           = pc;
                        data_nxt.raw_instr    = '0;
                        data_nxt.is_exception = 1'b1;
                        data_nxt.exception    = EXC_INSTR_MISALIGNED;
                        state_nxt             = S_EXC;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    data_nxt.en           = 1'b1;
                    data_nxt.pc           = pc;
                    data_nxt.raw_instr    = hold_instr;
                    data_nxt.is_exception = 1'b0;
                    data_nxt.exception    = '0;
                    pc_nxt                = pc_plus4;
                    state_nxt             = S_REQ;
                end
            end

            S_DRAIN: begin
                req_vld  = 1'b1;
                req_addr = drain_addr;
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end
                if (ibus.iresp_data_ok) begin
                    state_nxt = S_REQ;
                end
                if (!stall) begin
                    data_nxt.en = 1'b0;
                end
            end

            S_EXC: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    data_nxt.en = 1'b0;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // Flush beats stall: the slot is invalidated on any redirect.
        if (redirect_valid) begin
            data_nxt.en = 1'b0;
        end
    end

    assign ibus.ireq_valid = req_vld & ~reset;
    assign ibus.ireq_addr  = req_addr;

    assign dataF_en           = data_q.en;
    assign dataF_pc           = data_q.pc;
    assign dataF_raw_instr    = data_q.raw_instr;
    assign dataF_is_exception = data_q.is_exception;
    assign dataF_exception    = data_q.exception;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV64 pipeline; sits directly upstream of decode and produces the registered fetch_data_t fields it consumes (en, pc, raw_instr, exception flags).
- Owns the PC register and drives the instruction bus with a valid/data_ok handshake.
- Handles downstream stall through a one-entry hold buffer.
- Handles control-flow redirect (branch/jump/trap/mret) and discards in-flight responses.
- Raises instruction-address-misaligned exceptions itself.

Parameters:
- PC_RESET, 64'h8000_0000, PC value loaded on reset.
- XLEN, 64, width of PC/address.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ireq_valid  output  1  instruction request valid; held until ireq_data_ok.
- ireq_addr  output  XLEN  request address; stable while ireq_valid.
- iresp_data_ok  input  1  response valid this cycle.
- iresp_data  input  32  fetched instruction.
- stall  input  1  downstream cannot accept a new instruction this cycle.
- redirect_valid  input  1  flush and restart at redirect_pc.
- redirect_pc  input  XLEN  new PC.
- dataF_en  output  1  output slot holds a valid instruction.
- dataF_pc  output  XLEN  PC of the slot.
- dataF_raw_instr  output  32  instruction word.
- dataF_is_exception  output  1  slot carries a fetch exception.
- dataF_exception  output  4  mcause code; 0 = instruction-address-misaligned.

Behaviour:
- Reset (async):
  - pc = PC_RESET; state = REQ.
  - All dataF_* outputs = 0; ireq_valid = 0 combinationally during reset.
  - Reset mid-transaction abandons the request; the bus side tolerates this.
- States: REQ, HOLD, DRAIN, EXC. Output register updates only at rising edges.
- Output-register update rule: at any edge, if redirect_valid, dataF_en <= 0 (flush wins over stall). Otherwise, when stall = 1, all dataF_* hold their values.
- REQ, pc[1:0] == 0:
  - ireq_valid = 1, ireq_addr = pc.
  - data_ok and redirect: pc <= redirect_pc, response discarded, stay in REQ.
  - redirect without data_ok: drain_addr <= pc, pc <= redirect_pc, go to DRAIN.
  - data_ok, no redirect, stall = 0: dataF <= {en=1, pc, iresp_data, exc=0}, pc <= pc+4, stay in REQ. Back-to-back data_ok gives 1 instruction per cycle.
  - data_ok, no redirect, stall = 1: buf <= iresp_data, go to HOLD.
  - No data_ok, stall = 0: dataF_en <= 0 (bubble).
- REQ, pc[1:0] != 0:
  - ireq_valid = 0.
  - stall = 0: dataF <= {en=1, pc, raw_instr=0, is_exception=1, exception=0}, go to EXC.
  - Redirect: pc <= redirect_pc, stay in REQ.
- HOLD:
  - ireq_valid = 0.
  - Redirect: pc <= redirect_pc, buf discarded, go to REQ.
  - Else if stall = 0: dataF <= {1, pc, buf, 0}, pc <= pc+4, go to REQ.
- DRAIN:
  - ireq_valid = 1, ireq_addr = drain_addr.
  - data_ok: response discarded, go to REQ.
  - A further redirect updates pc only; stay in DRAIN unless data_ok also arrives.
- EXC:
  - ireq_valid = 0. If stall = 0, dataF_en <= 0 after the exception slot is accepted.
  - Stay in EXC until redirect: pc <= redirect_pc, go to REQ.
- Arithmetic: pc+4 is modulo 2^XLEN; wrap-around is not flagged.
- No instruction is ever emitted twice or dropped without a redirect.

Test Plan:
- Reset, then data_ok every cycle with instrs 0x00000013, 0x00100093, 0x00200113 -> ireq_addr 0x80000000/4/8; dataF pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, en = 1.
- stall = 1 for 3 cycles while data_ok returns 0x00A00513 at pc 0x80000004 -> enters HOLD; ireq_valid = 0; dataF unchanged; one cycle after stall drops, dataF = {1, 0x80000004, 0x00A00513}; next ireq_addr = 0x80000008.
- Redirect to 0x80001000 with the request at 0x80000008 outstanding and data_ok 2 cycles later -> DRAIN; ireq_addr stays 0x80000008; response discarded; next ireq_addr = 0x80001000; dataF_en = 0 meanwhile.
- Redirect and data_ok in the same cycle -> response dropped; next ireq_addr = redirect_pc; no DRAIN state.
- Redirect to 0x80000002 -> no request; dataF = {1, 0x80000002, 0, is_exception=1, exception=0}; then bubbles; a redirect to 0x80000100 resumes fetch.
- Assert reset while in DRAIN -> ireq_valid drops immediately; after release, ireq_addr = 0x80000000 and dataF_en = 0.
